// File: rtl/spi_deserializer.sv
// ----------------------------------------------------------------------------
// spi_deserializer
//
// Receive end of the attenuator control link. Samples an SPI triple
// (SPI_clk / DataBit / CS) with the fabric clock and rebuilds each frame
// into a parallel word. A frame is CS low, then Shift_BitCount bits sampled
// on SPI_clk rising edges (LSB first), then CS high.
//
// Ports:
//   clk          fabric clock, all logic on its rising edge
//   rst_n        active-low reset, asynchronous assert, synchronised release
//   SPI_clk      serial clock from the transmitter (asynchronous to clk)
//   DataBit      serial data (asynchronous to clk)
//   CS           chip select, active-low (asynchronous to clk)
//   Data_Out     last good frame, zero-extended; held between good frames
//   Data_Valid   one-cycle pulse when Data_Out updates
//   Frame_Error  one-cycle pulse when a frame closes with the wrong bit count
//   Busy         high while a frame is being received
// ----------------------------------------------------------------------------
module spi_deserializer #(
    parameter int Register_Width = 32,
    parameter int Shift_BitCount = 24,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SPI_clk,
    input  logic                      DataBit,
    input  logic                      CS,
    output logic [Register_Width-1:0] Data_Out,
    output logic                      Data_Valid,
    output logic                      Frame_Error,
    output logic                      Busy
);

    // Counter holds 0 .. Shift_BitCount+1; the top value marks an overlong frame.
    localparam int            CntW     = $clog2(Shift_BitCount + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(Shift_BitCount);
    localparam logic [CntW-1:0] CntOver = CntW'(Shift_BitCount + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset: assert asynchronously, release on a clk edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // NOTE: sequential state is written with non-blocking (<=) so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection. Chains reset to idle levels.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] spi_clk_sync_q, cs_sync_q, data_sync_q;
    logic [SYNC_STAGES-1:0] ready_q;
    logic                   spi_prev_q, cs_prev_q, armed_q;
    logic                   spi_s, cs_s, data_s, ready;
    logic                   spi_rise, cs_rise, cs_fall;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            spi_clk_sync_q <= '0;
            cs_sync_q      <= '1;
            data_sync_q    <= '0;
            spi_prev_q     <= 1'b0;
            cs_prev_q      <= 1'b1;
            ready_q        <= '0;
            armed_q        <= 1'b0;
        end else begin
            spi_clk_sync_q <= {spi_clk_sync_q[SYNC_STAGES-2:0], SPI_clk};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            data_sync_q    <= {data_sync_q[SYNC_STAGES-2:0], DataBit};
            spi_prev_q     <= spi_s;
            cs_prev_q      <= cs_s;
            ready_q        <= {ready_q[SYNC_STAGES-2:0], 1'b1};
            // Arm only after a real (not reset-forced) high CS level, so a
            // frame already under way at reset release is ignored.
            armed_q        <= armed_q | (ready & cs_s);
        end
    end

    assign spi_s    = spi_clk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    // High once the chains hold sampled input rather than reset levels.
    assign ready    = ready_q[SYNC_STAGES-1];
    assign spi_rise = spi_s & ~spi_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q & armed_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [Shift_BitCount-1:0] sr_q, sr_d, in_bit;
    logic [Register_Width-1:0] data_out_q, data_out_d;
    logic                      valid_q, valid_d, err_q, err_d;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        in_bit     = '0;
        in_bit[Shift_BitCount-1] = data_s;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            RECV: begin
                // A bit arriving with the closing CS edge is counted first.
                if (spi_rise && cnt_q != CntOver) begin
                    sr_d  = (sr_q >> 1) | in_bit;
                    cnt_d = cnt_q + CntW'(1);
                end
                if (cs_rise) state_d = DONE;
            end
            DONE: begin
                if (cnt_q == CntFull) begin
                    data_out_d = Register_Width'(sr_q);
                    valid_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                // A new frame starting right away is not lost.
                if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Data_Out    = data_out_q;
    assign Data_Valid  = valid_q;
    assign Frame_Error = err_q;
    assign Busy        = (state_q == RECV);

endmodule

// File: tb/tb_spi_deserializer.sv
module tb_spi_deserializer;

    localparam int RW  = 32;
    localparam int N   = 24;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;
    localparam logic [RW-1:0] MASK = RW'((64'd1 << N) - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          SPI_clk = 1'b0;
    logic          DataBit = 1'b0;
    logic          CS = 1'b1;
    logic [RW-1:0] Data_Out;
    logic          Data_Valid, Frame_Error, Busy;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            busy_bad = 0;
    logic [RW-1:0] exp_out = '0;

    typedef struct {
        bit            v;
        bit            e;
        int            cyc;
        logic [RW-1:0] d;
    } pulse_t;
    pulse_t pulse_q[$];

    spi_deserializer #(
        .Register_Width(RW),
        .Shift_BitCount(N),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SPI_clk    (SPI_clk),
        .DataBit    (DataBit),
        .CS         (CS),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Frame_Error(Frame_Error),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    // Record every cycle where a pulse output is high, with the cycle index.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (Data_Valid === 1'b1 || Frame_Error === 1'b1)
            pulse_q.push_back('{Data_Valid, Frame_Error, cyc, Data_Out});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame: CS low, nbits LSB-first, optionally CS high.
    // With coincide set, the last SPI_clk rise and CS rise happen together.
    task automatic send_frame(input logic [RW-1:0] data, input int nbits, input int hp,
                              input bit coincide, input bit raise_cs, output int rise_cyc);
        rise_cyc = -1;
        CS = 1'b0;
        SPI_clk = 1'b0;
        repeat (hp) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            DataBit = data[i];
            repeat (hp) @(negedge clk);
            if (coincide && raise_cs && i == nbits - 1) begin
                if (Busy !== 1'b1) busy_bad++;
                SPI_clk = 1'b1;
                CS = 1'b1;
                rise_cyc = cyc;
                repeat (hp) @(negedge clk);
                SPI_clk = 1'b0;
                return;
            end
            SPI_clk = 1'b1;
            repeat (hp) @(negedge clk);
            if (Busy !== 1'b1) busy_bad++;
            SPI_clk = 1'b0;
        end
        repeat (hp) @(negedge clk);
        if (Busy !== 1'b1) busy_bad++;
        if (raise_cs) begin
            CS = 1'b1;
            rise_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (Data_Out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", Data_Out); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Data_Valid); end
        checks++; if (Frame_Error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", Frame_Error); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        rst_n = 1'b1;
        settle(10);
        checks++; if (Data_Out !== '0 || Busy !== 1'b0 || pulse_q.size() != 0) begin
            errors++; $display("FAIL post_reset_idle: data=%h busy=%b pulses=%0d want 0/0/0", Data_Out, Busy, pulse_q.size());
        end
    endtask

    task automatic test_good_frame();
        int r;
        pulse_q.delete(); busy_bad = 0;
        send_frame(32'h00A5C30F, N, 8, 1'b0, 1'b1, r);
        settle(10);
        exp_out = 32'h00A5C30F;
        checks++; if (pulse_q.size() != 1) begin errors++; $display("FAIL good_pulses: got %0d want 1", pulse_q.size()); end
        else begin
            checks++; if (pulse_q[0].v !== 1'b1 || pulse_q[0].e !== 1'b0) begin
                errors++; $display("FAIL good_kind: got v=%b e=%b want v=1 e=0", pulse_q[0].v, pulse_q[0].e); end
            checks++; if (pulse_q[0].cyc !== r + LAT) begin
                errors++; $display("FAIL good_latency: got %0d want %0d", pulse_q[0].cyc - r, LAT); end
            checks++; if (pulse_q[0].d !== exp_out) begin
                errors++; $display("FAIL good_data_at_pulse: got %h want %h", pulse_q[0].d, exp_out); end
        end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL good_data: got %h want %h", Data_Out, exp_out); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b want 0", Busy); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL good_busy_during: got %0d low samples want 0", busy_bad); end
    endtask

    task automatic test_short_frame();
        int r;
        pulse_q.delete();
        send_frame(32'h00000001, N - 1, 8, 1'b0, 1'b1, r);
        settle(10);
        checks++; if (pulse_q.size() != 1) begin errors++; $display("FAIL short_pulses: got %0d want 1", pulse_q.size()); end
        else begin
            checks++; if (pulse_q[0].v !== 1'b0 || pulse_q[0].e !== 1'b1) begin
                errors++; $display("FAIL short_kind: got v=%b e=%b want v=0 e=1", pulse_q[0].v, pulse_q[0].e); end
            checks++; if (pulse_q[0].cyc !== r + LAT) begin
                errors++; $display("FAIL short_latency: got %0d want %0d", pulse_q[0].cyc - r, LAT); end
        end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL short_data_held: got %h want %h", Data_Out, exp_out); end
    endtask

    task automatic test_overlong_empty();
        int r;
        pulse_q.delete();
        send_frame(RW'($urandom), N + 1, 8, 1'b0, 1'b1, r);
        settle(10);
        checks++; if (pulse_q.size() != 1 || pulse_q[0].e !== 1'b1 || pulse_q[0].v !== 1'b0) begin
            errors++; $display("FAIL overlong_err: got %0d pulses (want one Frame_Error only)", pulse_q.size()); end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL overlong_data_held: got %h want %h", Data_Out, exp_out); end
        pulse_q.delete();
        send_frame('0, 0, 8, 1'b0, 1'b1, r);
        settle(10);
        checks++; if (pulse_q.size() != 1 || pulse_q[0].e !== 1'b1 || pulse_q[0].v !== 1'b0) begin
            errors++; $display("FAIL empty_err: got %0d pulses (want one Frame_Error only)", pulse_q.size()); end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL empty_data_held: got %h want %h", Data_Out, exp_out); end
    endtask

    task automatic test_back_to_back();
        int r1, r2;
        pulse_q.delete(); busy_bad = 0;
        send_frame(32'h00123456, N, 8, 1'b0, 1'b1, r1);
        settle(4);
        send_frame(32'h00FFFFFF, N, 8, 1'b0, 1'b1, r2);
        settle(10);
        exp_out = 32'h00FFFFFF;
        checks++; if (pulse_q.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulse_q.size()); end
        else begin
            checks++; if (pulse_q[0].v !== 1'b1 || pulse_q[0].d !== 32'h00123456 || pulse_q[0].cyc !== r1 + LAT) begin
                errors++; $display("FAIL b2b_first: got v=%b d=%h lat=%0d want v=1 d=00123456 lat=%0d",
                                   pulse_q[0].v, pulse_q[0].d, pulse_q[0].cyc - r1, LAT); end
            checks++; if (pulse_q[1].v !== 1'b1 || pulse_q[1].d !== 32'h00FFFFFF || pulse_q[1].cyc !== r2 + LAT) begin
                errors++; $display("FAIL b2b_second: got v=%b d=%h lat=%0d want v=1 d=00ffffff lat=%0d",
                                   pulse_q[1].v, pulse_q[1].d, pulse_q[1].cyc - r2, LAT); end
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy_during: got %0d low samples want 0", busy_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int r;
        pulse_q.delete();
        send_frame(RW'($urandom), 10, 8, 1'b0, 1'b0, r);
        rst_n = 1'b0;
        #1;
        exp_out = '0;
        checks++; if (Data_Out !== '0 || Data_Valid !== 1'b0 || Frame_Error !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got data=%h v=%b e=%b busy=%b want all 0",
                               Data_Out, Data_Valid, Frame_Error, Busy); end
        settle(3);
        rst_n = 1'b1;
        settle(12);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_ignored: got %b want 0", Busy); end
        CS = 1'b1;
        settle(12);
        checks++; if (pulse_q.size() != 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d want 0", pulse_q.size()); end
        send_frame(32'h0000BEEF, N, 8, 1'b0, 1'b1, r);
        settle(10);
        exp_out = 32'h0000BEEF;
        checks++; if (pulse_q.size() != 1 || pulse_q[0].v !== 1'b1) begin
            errors++; $display("FAIL midreset_next_frame: got %0d pulses want one Data_Valid", pulse_q.size()); end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL midreset_data: got %h want %h", Data_Out, exp_out); end
    endtask

    task automatic test_coincident();
        int r;
        logic [RW-1:0] d;
        pulse_q.delete();
        d = RW'($urandom);
        send_frame(d, N, 8, 1'b1, 1'b1, r);
        settle(10);
        exp_out = d & MASK;
        checks++; if (pulse_q.size() != 1 || pulse_q[0].v !== 1'b1 || pulse_q[0].cyc !== r + LAT) begin
            errors++; $display("FAIL coincide_valid: got %0d pulses want one Data_Valid at latency %0d", pulse_q.size(), LAT); end
        checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL coincide_data: got %h want %h", Data_Out, exp_out); end
    endtask

    task automatic test_random();
        int r, nb, hp, sel;
        bit co, good;
        logic [RW-1:0] d;
        for (int k = 0; k < 8; k++) begin
            pulse_q.delete(); busy_bad = 0;
            d   = RW'($urandom);
            sel = $urandom_range(0, 3);
            nb  = (sel == 0) ? N - 1 : (sel == 1) ? N + 1 : N;
            hp  = $urandom_range(4, 10);
            co  = 1'($urandom_range(0, 1));
            send_frame(d, nb, hp, co, 1'b1, r);
            settle($urandom_range(8, 14));
            good = (nb == N);
            if (good) exp_out = d & MASK;
            checks++; if (pulse_q.size() != 1) begin
                errors++; $display("FAIL rand%0d_pulses: got %0d want 1", k, pulse_q.size()); end
            else begin
                checks++; if (pulse_q[0].v !== good || pulse_q[0].e !== !good || pulse_q[0].cyc !== r + LAT) begin
                    errors++; $display("FAIL rand%0d_kind: got v=%b e=%b lat=%0d want v=%b e=%b lat=%0d",
                                       k, pulse_q[0].v, pulse_q[0].e, pulse_q[0].cyc - r, good, !good, LAT); end
            end
            checks++; if (Data_Out !== exp_out) begin errors++; $display("FAIL rand%0d_data: got %h want %h", k, Data_Out, exp_out); end
            checks++; if (busy_bad != 0 || Busy !== 1'b0) begin
                errors++; $display("FAIL rand%0d_busy: got %0d low samples, busy=%b after; want 0, 0", k, busy_bad, Busy); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_overlong_empty();
        test_back_to_back();
        test_reset_mid_frame();
        test_coincident();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_deserializer.md
Name: spi_deserializer

Overview:
- SPI receive end of the attenuator control link: samples an external SPI_clk/DataBit/CS triple with the fabric clock and reassembles each frame into a parallel word.
- Used as the loopback checker for the attenuator serializer on the ZCU111 and as a daughter-board readback port.
- Wire format matches the team's serializer: CS active-low, data sampled on SPI_clk rising edge, LSB first, Shift_BitCount bits per frame.

Parameters:
- Register_Width, 32, width of Data_Out; bits at and above Shift_BitCount read 0.
- Shift_BitCount, 24, exact number of bits in a valid frame; 1 ≤ Shift_BitCount ≤ Register_Width.
- SYNC_STAGES, 2, synchroniser depth on each SPI input; minimum 2.

Ports:
- clk  input  1  fabric clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; release is synchronised internally.
- SPI_clk  input  1  serial clock from the transmitter, asynchronous to clk.
- DataBit  input  1  serial data, asynchronous to clk.
- CS  input  1  chip select, active-low, asynchronous to clk.
- Data_Out  output  Register_Width  last good frame; holds its value until the next good frame.
- Data_Valid  output  1  one-cycle pulse when Data_Out updates.
- Frame_Error  output  1  one-cycle pulse when a frame ends with the wrong bit count.
- Busy  output  1  high while a frame is in progress (state RECV).

Behaviour:
- Reset values: Data_Out=0, Data_Valid=0, Frame_Error=0, Busy=0, state=IDLE, bit counter=0, synchronisers=idle levels (SPI_clk=0, CS=1, DataBit=0).
- Synchronisation:
  - SPI_clk, CS and DataBit each pass through a SYNC_STAGES flop chain.
  - Edges are detected on the synchronised SPI_clk and CS by comparing with a one-cycle-delayed copy.
- Timing requirement: SPI_clk high and low phases are each ≥ SYNC_STAGES+1 clk periods. DataBit is stable across the synchronised rising edge. Faster input is unsupported and gives undefined results.
- State IDLE:
  - A synchronised CS falling edge clears the shift register and bit counter and moves to RECV.
  - SPI_clk edges in IDLE are ignored.
- State RECV:
  - On each synchronised SPI_clk rising edge, the shift register shifts right. The synchronised DataBit enters at bit Shift_BitCount-1, and the counter increments.
  - After exactly Shift_BitCount bits, the first received bit sits at Data_Out bit 0.
  - The counter saturates at Shift_BitCount+1; further edges are ignored but the frame stays marked overlong.
  - A synchronised CS rising edge moves to DONE.
- State DONE (single cycle, then IDLE):
  - Counter == Shift_BitCount: Data_Out takes the shift register, zero-extended, and Data_Valid=1.
  - Any other count, including 0 and overlong: Frame_Error=1 and Data_Out is unchanged.
- Latency:
  - Data_Valid/Frame_Error rise SYNC_STAGES+2 clk cycles after the external CS rising edge.
  - The pulse is exactly one cycle wide.
- Simultaneous events:
  - If an SPI_clk rising edge and the CS rising edge are detected in the same cycle, the bit is counted first, then the frame closes.
  - A CS falling edge seen in DONE is honoured: the next cycle enters RECV.
- Busy = (state == RECV).
- Reset mid-frame: everything returns to reset values at once; the partial frame is discarded with no pulse. After release, a frame already in progress (CS low) is ignored until CS goes high and then low again.

Test Plan:
- Good frame: rst_n low 5 cycles then high. Send 24'hA5C30F LSB-first with 8-clk SPI half-periods, CS low → Data_Out=32'h00A5C30F, Data_Valid high for exactly 1 cycle, 4 cycles after CS rises. Frame_Error stays 0.
- Short frame: send 23 bits of 24'h000001 → Frame_Error pulses once, Data_Valid stays 0, Data_Out keeps its previous value 32'h00A5C30F.
- Overlong and empty frames: a 25-bit frame → Frame_Error. A CS low/high pulse with no SPI_clk edges → Frame_Error. Data_Out unchanged in both cases.
- Back-to-back frames: 24'h123456 then 24'hFFFFFF with CS high for only 4 clk between them → two Data_Valid pulses. Data_Out reads 32'h00123456, then 32'h00FFFFFF.
- Reset mid-frame: assert rst_n after 10 bits → all outputs 0 immediately. With CS still low after release, no pulse at the following CS rise. The next full frame 24'h00BEEF → Data_Out=32'h0000BEEF.
- Boundary: last SPI_clk rise and CS rise coincide externally → frame is accepted as 24 bits with Data_Valid. Busy is high throughout every frame and low otherwise.
